// File: rtl/sys_defs.sv
// Shared sizing constants and the map-table entry type for the rename stage.
package sys_defs;
    localparam int N_ARCH   = 32;
    localparam int N_PHYS   = 64;
    localparam int XLEN     = 32;
    localparam int PW       = $clog2(N_PHYS);
    localparam int AW       = $clog2(N_ARCH);
    localparam int FL_DEPTH = N_PHYS - N_ARCH;
    localparam int FL_CW    = $clog2(FL_DEPTH) + 1;

    typedef struct packed {
        logic [PW-1:0] phys_reg;
        logic          ready;
        logic          valid;
    } tag_t;
endpackage

// File: rtl/rr_free_fifo.sv
// Circular free list of physical tags; reset preloads BASE..BASE+DEPTH-1.
module rr_free_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int BASE  = N_ARCH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [PW-1:0]             push_tag,
    input  logic                      pop,
    output logic [PW-1:0]             head_tag,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);
    localparam int QW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    // Status flags come only from registered count, never from this cycle's push.
    assign empty    = (count == '0);
    assign full     = (count == (QW+1)'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_tag = mem[head];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PW'(BASE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= (QW+1)'(DEPTH);
        end else begin
            if (push_ok) begin
                mem[tail] <= push_tag;
                tail      <= tail + 1'b1;
            end
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            count <= count + (QW+1)'(push_ok) - (QW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/rename_regfile.sv
// Single-wide register rename: map table, free list and physical register file.
module rename_regfile
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             rn_en,
    input  logic [AW-1:0]    rn_rs1,
    input  logic [AW-1:0]    rn_rs2,
    input  logic [AW-1:0]    rn_rd,
    input  logic             rn_rd_valid,
    output logic [PW-1:0]    rn_t1,
    output logic [PW-1:0]    rn_t2,
    output logic             rn_t1_ready,
    output logic             rn_t2_ready,
    output logic [PW-1:0]    rn_t,
    output logic [PW-1:0]    rn_told,
    output logic             fl_empty,
    output logic [FL_CW-1:0] fl_count,
    input  logic             cdb_en,
    input  logic [PW-1:0]    cdb_tag,
    input  logic [PW-1:0]    rd_tag1,
    input  logic [PW-1:0]    rd_tag2,
    output logic [XLEN-1:0]  rd_data1,
    output logic [XLEN-1:0]  rd_data2,
    input  logic             wb_en,
    input  logic [PW-1:0]    wb_tag,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             rt_en,
    input  logic [PW-1:0]    rt_told
);
    tag_t            map [N_ARCH];
    logic [XLEN-1:0] prf [N_PHYS];
    logic [PW-1:0]   fl_head;
    logic            fl_full;
    logic            alloc;

    assign alloc = rn_en && rn_rd_valid && (rn_rd != '0) && !fl_empty;

    rr_free_fifo u_free_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rt_en && (rt_told != '0)),
        .push_tag (rt_told),
        .pop      (alloc),
        .head_tag (fl_head),
        .count    (fl_count),
        .empty    (fl_empty),
        .full     (fl_full)
    );

    // Lookups see the pre-rename map, with same-cycle CDB forwarding of ready.
    always_comb begin
        rn_t1       = map[rn_rs1].phys_reg;
        rn_t2       = map[rn_rs2].phys_reg;
        rn_t1_ready = map[rn_rs1].ready || (cdb_en && (cdb_tag == rn_t1));
        rn_t2_ready = map[rn_rs2].ready || (cdb_en && (cdb_tag == rn_t2));
        rn_t        = alloc ? fl_head : '0;
        rn_told     = map[rn_rd].phys_reg;
    end

    always_comb begin
        rd_data1 = prf[rd_tag1];
        rd_data2 = prf[rd_tag2];
        if (wb_en && (wb_tag != '0) && (wb_tag == rd_tag1)) rd_data1 = wb_data;
        if (wb_en && (wb_tag != '0) && (wb_tag == rd_tag2)) rd_data2 = wb_data;
        if (rd_tag1 == '0) rd_data1 = '0;
        if (rd_tag2 == '0) rd_data2 = '0;
    end

    // A rename of an entry overrides a same-cycle CDB wakeup of its old tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_ARCH; i++) begin
                map[i] <= '{phys_reg: PW'(i), ready: 1'b1, valid: 1'b1};
            end
        end else begin
            for (int i = 0; i < N_ARCH; i++) begin
                if (cdb_en && (map[i].phys_reg == cdb_tag)) begin
                    map[i].ready <= 1'b1;
                end
                if (alloc && (rn_rd == AW'(i))) begin
                    map[i] <= '{phys_reg: fl_head, ready: 1'b0, valid: 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PHYS; i++) begin
                prf[i] <= '0;
            end
        end else if (wb_en && (wb_tag != '0)) begin
            prf[wb_tag] <= wb_data;
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed vector table plus hand sequences for free-list drain/wrap, PRF bypass and reset.
module tb_rename_regfile;
    logic        clock = 1'b0;
    logic        reset;
    logic        rn_en, rn_rd_valid, cdb_en, wb_en, rt_en;
    logic [4:0]  rn_rs1, rn_rs2, rn_rd;
    logic [5:0]  rn_t1, rn_t2, rn_t, rn_told, cdb_tag, rd_tag1, rd_tag2, wb_tag, rt_told;
    logic        rn_t1_ready, rn_t2_ready, fl_empty;
    logic [5:0]  fl_count;
    logic [31:0] rd_data1, rd_data2, wb_data;

    int nvec = 0;
    int nerr = 0;

    rename_regfile dut (
        .clock(clock), .reset(reset),
        .rn_en(rn_en), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd), .rn_rd_valid(rn_rd_valid),
        .rn_t1(rn_t1), .rn_t2(rn_t2), .rn_t1_ready(rn_t1_ready), .rn_t2_ready(rn_t2_ready),
        .rn_t(rn_t), .rn_told(rn_told), .fl_empty(fl_empty), .fl_count(fl_count),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
        .rt_en(rt_en), .rt_told(rt_told)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic [4:0] rs1, rs2, rd;
        logic       rdv, cen;
        logic [5:0] ctag;
        logic       rten;
        logic [5:0] rtt;
        logic [5:0] t1;
        logic       t1r;
        logic [5:0] t2;
        logic       t2r;
        logic [5:0] t, told, cnt;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(logic en, int rs1, int rs2, int rd, logic rdv, logic cen, int ctag,
                                logic rten, int rtt, int t1, logic t1r, int t2, logic t2r,
                                int t, int told, int cnt);
        vec_t v;
        v.en = en; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.rdv = rdv;
        v.cen = cen; v.ctag = 6'(ctag); v.rten = rten; v.rtt = 6'(rtt);
        v.t1 = 6'(t1); v.t1r = t1r; v.t2 = 6'(t2); v.t2r = t2r;
        v.t = 6'(t); v.told = 6'(told); v.cnt = 6'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rn_en = 0; rn_rs1 = 0; rn_rs2 = 0; rn_rd = 0; rn_rd_valid = 0;
        cdb_en = 0; cdb_tag = 0; rd_tag1 = 0; rd_tag2 = 0;
        wb_en = 0; wb_tag = 0; wb_data = 0; rt_en = 0; rt_told = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rename(input int rs1, input int rs2, input int rd, input logic en);
        rn_en = en; rn_rs1 = 5'(rs1); rn_rs2 = 5'(rs2); rn_rd = 5'(rd); rn_rd_valid = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        rn_en = 0;
        for (int i = 0; i < 32; i++) begin
            rn_rs1 = 5'(i);
            #1;
            chk({tag, "_map_tag"}, 32'(rn_t1), 32'(i));
            chk({tag, "_map_rdy"}, 32'(rn_t1_ready), 32'd1);
        end
        chk({tag, "_fl_count"}, 32'(fl_count), 32'd32);
        chk({tag, "_fl_empty"}, 32'(fl_empty), 32'd0);
        rename(1, 2, 9, 1'b1);
        #1;
        chk({tag, "_head_tag"}, 32'(rn_t), 32'd32);
        rd_tag1 = 6'd40; rd_tag2 = 6'd63;
        #1;
        chk({tag, "_prf40"}, rd_data1, 32'd0);
        chk({tag, "_prf63"}, rd_data2, 32'd0);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_reset_state("rst0");

        // A push against a full list must be dropped.
        rt_en = 1; rt_told = 6'd9;
        tick();
        idle();
        #1;
        chk("full_push_ignored", 32'(fl_count), 32'd32);

        vt[0]  = mk(1, 5, 3, 7, 1, 0, 0, 0, 0,    5, 1, 3, 1, 32, 7, 32);
        vt[1]  = mk(1, 6, 0, 6, 1, 0, 0, 0, 0,    6, 1, 0, 1, 33, 6, 31);
        vt[2]  = mk(1, 7, 0, 7, 1, 0, 0, 0, 0,   32, 0, 0, 1, 34, 32, 30);
        vt[3]  = mk(1, 7, 6, 15, 1, 1, 33, 0, 0, 34, 0, 33, 1, 35, 15, 29);
        vt[4]  = mk(0, 6, 7, 7, 1, 1, 32, 0, 0,  33, 1, 34, 0, 0, 34, 28);
        vt[5]  = mk(0, 7, 15, 15, 1, 0, 0, 0, 0, 34, 0, 35, 0, 0, 35, 28);
        vt[6]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0,    0, 1, 1, 1, 0, 0, 28);
        vt[7]  = mk(1, 3, 3, 3, 0, 0, 0, 0, 0,    3, 1, 3, 1, 0, 3, 28);
        vt[8]  = mk(1, 5, 5, 5, 1, 0, 0, 0, 0,    5, 1, 5, 1, 36, 5, 28);
        vt[9]  = mk(1, 5, 0, 5, 1, 1, 36, 0, 0,  36, 1, 0, 1, 37, 36, 27);
        vt[10] = mk(0, 5, 0, 5, 1, 0, 0, 0, 0,   37, 0, 0, 1, 0, 37, 26);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7,    0, 1, 0, 1, 0, 0, 26);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0,    0, 1, 0, 1, 0, 0, 27);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1, 0, 0, 27);
        vt[14] = mk(1, 0, 0, 1, 1, 0, 0, 1, 6,    0, 1, 0, 1, 38, 1, 27);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1, 0, 0, 27);

        for (int k = 0; k < 16; k++) begin
            rn_en = vt[k].en; rn_rs1 = vt[k].rs1; rn_rs2 = vt[k].rs2; rn_rd = vt[k].rd;
            rn_rd_valid = vt[k].rdv; cdb_en = vt[k].cen; cdb_tag = vt[k].ctag;
            rt_en = vt[k].rten; rt_told = vt[k].rtt;
            #3;
            chk($sformatf("v%0d_t1", k), 32'(rn_t1), 32'(vt[k].t1));
            chk($sformatf("v%0d_t1r", k), 32'(rn_t1_ready), 32'(vt[k].t1r));
            chk($sformatf("v%0d_t2", k), 32'(rn_t2), 32'(vt[k].t2));
            chk($sformatf("v%0d_t2r", k), 32'(rn_t2_ready), 32'(vt[k].t2r));
            chk($sformatf("v%0d_t", k), 32'(rn_t), 32'(vt[k].t));
            chk($sformatf("v%0d_told", k), 32'(rn_told), 32'(vt[k].told));
            chk($sformatf("v%0d_cnt", k), 32'(fl_count), 32'(vt[k].cnt));
            tick();
            idle();
        end

        // Drain: list holds 39..63 followed by the retired tags 7 and 6.
        for (int k = 0; k < 27; k++) begin
            rename(0, 0, 2, 1'b1);
            #2;
            chk($sformatf("drain%0d_t", k), 32'(rn_t), (k < 25) ? 32'(39 + k) : ((k == 25) ? 32'd7 : 32'd6));
            chk($sformatf("drain%0d_cnt", k), 32'(fl_count), 32'(27 - k));
            tick();
        end
        #1;
        chk("empty_flag", 32'(fl_empty), 32'd1);
        chk("empty_count", 32'(fl_count), 32'd0);
        chk("empty_no_alloc", 32'(rn_t), 32'd0);
        // Retire into an empty list together with a request: no allocation this cycle.
        rt_en = 1; rt_told = 6'd7;
        #1;
        chk("push_pop_empty_t", 32'(rn_t), 32'd0);
        tick();
        rt_en = 0; rt_told = 0;
        #1;
        chk("after_push_count", 32'(fl_count), 32'd1);
        chk("after_push_empty", 32'(fl_empty), 32'd0);
        chk("wrap_alloc_t", 32'(rn_t), 32'd7);
        tick();
        idle();
        #1;
        chk("wrap_count_zero", 32'(fl_count), 32'd0);

        // PRF write, bypass and tag-0 behavior.
        wb_en = 1; wb_tag = 6'd40; wb_data = 32'hDEADBEEF; rd_tag1 = 6'd40; rd_tag2 = 6'd41;
        #1;
        chk("prf_bypass1", rd_data1, 32'hDEADBEEF);
        chk("prf_no_bypass2", rd_data2, 32'd0);
        tick();
        wb_en = 1; wb_tag = 6'd0; wb_data = 32'h12345678; rd_tag1 = 6'd0; rd_tag2 = 6'd40;
        #1;
        chk("prf_tag0_bypass", rd_data1, 32'd0);
        chk("prf_stored40", rd_data2, 32'hDEADBEEF);
        tick();
        wb_en = 0;
        #1;
        chk("prf_tag0_stored", rd_data1, 32'd0);

        // Reset mid-operation wins over a same-cycle rename, write and retire.
        reset = 1; rename(3, 4, 5, 1'b1); wb_en = 1; wb_tag = 6'd50; wb_data = 32'hA5A5A5A5;
        rt_en = 1; rt_told = 6'd12; cdb_en = 1; cdb_tag = 6'd5;
        tick();
        reset = 0;
        idle();
        #1;
        check_reset_state("rst1");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
